bcd_alu_seq: RTL and testbench
==============================

Name: bcd_alu_seq

Overview:
- Digit-serial BCD add/subtract unit for the calculator datapath, parametrised in digit count.
- Sits between the keypad/FSM operand registers and the display driver.
- Operands are captured on a start pulse. One BCD digit is processed per clock, LSD first. Results come back with done/flag outputs.
- Adds a handshake, operand validation, overflow flagging and an optional signed-result mode.

Parameters:
DIGITS, 4, number of BCD digits per operand and result (>=1); vector width W = 4*DIGITS

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only when not busy
operation  in  2  2'b10 = subtract, any other code = add (keypad/FSM encoding)
num1_bcd  in  W  operand A, nibble i = digit i (nibble 0 = units)
num2_bcd  in  W  operand B, same packing
busy  out  1  high while computing
done  out  1  one-cycle pulse, result/flags valid from this cycle
result_bcd  out  W  result in BCD, held until next accepted start
ovf  out  1  result saturated (add overflow, or sub underflow without BCD_ALU_NEG_EN)
neg  out  1  result is negative magnitude (BCD_ALU_NEG_EN only, else tied 0)
err  out  1  an operand contained a nibble > 9

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, result_bcd=0, ovf=0, neg=0, err=0; internal operand/carry/digit counter cleared. Reset mid-computation aborts with no done pulse.
- States: IDLE, CALC, FIX (BCD_ALU_NEG_EN only), DONE.
- Start acceptance:
  - start is accepted in IDLE or DONE.
  - On accept: latch num1_bcd, num2_bcd and is_sub (operation==2'b10); clear carry/borrow and the digit counter k; clear ovf/neg/err.
  - start in CALC/FIX is ignored and not queued.
- Validation: if any latched nibble > 9, go directly to DONE next cycle with err=1, result_bcd=0, ovf=0. Latency is 1 cycle.
- CALC (DIGITS cycles, k = 0..DIGITS-1):
  - Add: s = a_k + b_k + c. If s > 9, write s+6 (low nibble) and set c=1; else write s and set c=0.
  - Sub: d = a_k - b_k - c (5-bit). If negative, write d+10 and set c=1; else write d and set c=0.
  - Digit k is written into the result shift register.
- End of CALC (after digit DIGITS-1), based on the final carry c:
  - Add, c=1: result = all 9s, ovf=1.
  - Sub, c=1 (A<B): without the feature, result = 0 and ovf=1; with the feature, go to FIX.
  - Otherwise the result is as computed.
  - Then go to DONE.
- FIX (DIGITS cycles): computes the ten's complement of the CALC result digit-serially (0 - r with borrow, same per-digit rule as sub). Sets neg=1, then goes to DONE.
- busy = 1 in CALC and FIX only.
- DONE: done=1 for exactly one cycle, then IDLE unless a new start is accepted in that cycle. result_bcd and flags hold until the next accepted start.
- Latency from the start edge to the done cycle:
  - Normal: DIGITS+1.
  - FIX path: 2*DIGITS+1.
  - err path: 1.
- Equal operands on sub: result 0, ovf=0, neg=0.
- operation is sampled only at accept; later changes have no effect.

Optional Feature:
- Macro BCD_ALU_NEG_EN.
- Defined: FIX state present; A<B on subtract yields |A-B| with neg=1 and ovf=0.
- Undefined: no FIX state; A<B on subtract saturates to 0 with ovf=1; neg tied to 0.

Test Plan:
- DIGITS=4, add 1234+4321, start one cycle -> busy 4 cycles, done at start+5, result 5555, ovf=0, err=0.
- Add 9999+0001 -> result 9999, ovf=1; add 0999+0001 -> 1000, ovf=0 (carry ripple across three digits).
- Sub 0100-0001 -> 0099, neg=0. Sub 0001-0100 without macro -> 0000, ovf=1, done at start+5. Same with BCD_ALU_NEG_EN -> 0099, neg=1, ovf=0, done at start+9.
- num1_bcd=16'h12A4, start -> done at start+1, err=1, result 0000; next start with valid operands clears err.
- start reasserted every cycle while busy -> only the first is accepted, a single done pulse. Start asserted in the DONE cycle -> accepted back-to-back, second result correct.
- rst_n pulled low at CALC digit 2 -> all outputs 0 immediately, no done pulse. After release, a fresh 0005+0005 gives 0010.

Source files
------------

// File: rtl/bcd_alu_seq.sv
// Digit-serial BCD add/subtract unit, one digit per clock, LSD first.
// Ports: clk, rst_n (async low), start, operation (2'b10 = sub),
//   num1_bcd/num2_bcd (4*DIGITS) in; busy, done, result_bcd, ovf,
//   neg, err out. Macro BCD_ALU_NEG_EN enables signed (FIX) results.
module bcd_alu_seq #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            operation,
  input  logic [4*DIGITS-1:0]   num1_bcd,
  input  logic [4*DIGITS-1:0]   num2_bcd,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result_bcd,
  output logic                  ovf,
  output logic                  neg,
  output logic                  err
);

  localparam int W  = 4 * DIGITS;
  localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  w_q, w_d;
  logic [W-1:0]  res_q, res_d;
  logic [KW-1:0] k_q, k_d;
  logic          c_q, c_d;
  logic          sub_q, sub_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;
`ifdef BCD_ALU_NEG_EN
  logic          neg_q, neg_d;
`endif

  // {carry/borrow out, result digit} for one BCD digit
  function automatic logic [4:0] dig_op(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic       ci,
    input logic       sub
  );
    logic [4:0] s;
    if (sub) begin
      s = {1'b0, a} - {1'b0, b} - {4'b0, ci};
      if (s[4]) return {1'b1, s[3:0] + 4'd10};
      else      return {1'b0, s[3:0]};
    end else begin
      s = {1'b0, a} + {1'b0, b} + {4'b0, ci};
      if (s > 5'd9) return {1'b1, s[3:0] + 4'd6};
      else          return {1'b0, s[3:0]};
    end
  endfunction

  function automatic logic bad_bcd(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  logic         accept;
  logic         last;
  logic         in_fix;
  logic [4:0]   step;
  logic [W+3:0] shin;
  logic [W-1:0] w_nx;

  assign accept = start &&
                  (state_q == S_IDLE || state_q == S_DONE);
  assign last   = (k_q == KW'(DIGITS - 1));
  assign in_fix = (state_q == S_FIX);

  // FIX reuses the subtract rule as 0 - r, giving the ten's complement
  assign step = dig_op(in_fix ? 4'd0 : a_q[3:0],
                       in_fix ? w_q[3:0] : b_q[3:0],
                       c_q,
                       in_fix | sub_q);

  // new digit enters at the top so digit 0 lands at the bottom
  assign shin = {step[3:0], w_q};
  assign w_nx = shin[W+3:4];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    w_d     = w_q;
    res_d   = res_q;
    k_d     = k_q;
    c_d     = c_q;
    sub_d   = sub_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
`ifdef BCD_ALU_NEG_EN
    neg_d   = neg_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          a_d   = num1_bcd;
          b_d   = num2_bcd;
          sub_d = (operation == 2'b10);
          w_d   = '0;
          res_d = '0;
          k_d   = '0;
          c_d   = 1'b0;
          ovf_d = 1'b0;
          err_d = 1'b0;
`ifdef BCD_ALU_NEG_EN
          neg_d = 1'b0;
`endif
          if (bad_bcd(num1_bcd) || bad_bcd(num2_bcd)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        a_d = a_q >> 4;
        b_d = b_q >> 4;
        w_d = w_nx;
        c_d = step[4];
        k_d = k_q + 1'b1;
        if (last) begin
          k_d     = '0;
          c_d     = 1'b0;
          state_d = S_DONE;
          if (step[4] && !sub_q) begin
            res_d = {DIGITS{4'h9}};
            ovf_d = 1'b1;
          end else if (step[4]) begin
`ifdef BCD_ALU_NEG_EN
            state_d = S_FIX;
`else
            res_d = '0;
            ovf_d = 1'b1;
`endif
          end else begin
            res_d = w_nx;
          end
        end
      end
      S_FIX: begin
        w_d = w_nx;
        c_d = step[4];
        k_d = k_q + 1'b1;
        if (last) begin
          k_d     = '0;
          c_d     = 1'b0;
          res_d   = w_nx;
`ifdef BCD_ALU_NEG_EN
          neg_d   = 1'b1;
`endif
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      w_q     <= '0;
      res_q   <= '0;
      k_q     <= '0;
      c_q     <= 1'b0;
      sub_q   <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef BCD_ALU_NEG_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      w_q     <= w_d;
      res_q   <= res_d;
      k_q     <= k_d;
      c_q     <= c_d;
      sub_q   <= sub_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
`ifdef BCD_ALU_NEG_EN
      neg_q   <= neg_d;
`endif
    end
  end

  assign busy       = (state_q == S_CALC) || (state_q == S_FIX);
  assign done       = (state_q == S_DONE);
  assign result_bcd = res_q;
  assign ovf        = ovf_q;
  assign err        = err_q;
`ifdef BCD_ALU_NEG_EN
  assign neg        = neg_q;
`else
  assign neg        = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_alu_seq.sv
// Bench for bcd_alu_seq (DIGITS=4): integer-level model plus
// directed vectors with hand-computed results and latencies.
module tb_bcd_alu_seq;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int MAXV   = 9999;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   operation = 2'b00;
  logic [W-1:0] num1_bcd = '0;
  logic [W-1:0] num2_bcd = '0;
  logic         busy, done, ovf, neg, err;
  logic [W-1:0] result_bcd;

  bcd_alu_seq #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .operation(operation),
    .num1_bcd(num1_bcd), .num2_bcd(num2_bcd),
    .busy(busy), .done(done), .result_bcd(result_bcd),
    .ovf(ovf), .neg(neg), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  // model state: expectations for the most recent accepted start
  int           t0 = -100;
  int           lat = 0;
  logic [W-1:0] eres = '0;
  logic         eovf = 1'b0;
  logic         eneg = 1'b0;
  logic         eerr = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v,
                                 output bit bad);
    int r;
    logic [3:0] d;
    r = 0;
    bad = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = v[4*i +: 4];
      if (d > 4'd9) bad = 1;
      r = r * 10 + int'(d);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int x);
    logic [W-1:0] r;
    int y;
    r = '0;
    y = x;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(y % 10);
      y = y / 10;
    end
    return r;
  endfunction

  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] opc);
    int ai, bi;
    bit ba, bb;
    ai   = bcd2int(a, ba);
    bi   = bcd2int(b, bb);
    t0   = cyc;
    eres = '0;
    eovf = 0;
    eneg = 0;
    eerr = 0;
    lat  = DIGITS + 1;
    if (ba || bb) begin
      eerr = 1;
      lat  = 1;
    end else if (opc != 2'b10) begin
      if (ai + bi > MAXV) begin
        eres = int2bcd(MAXV);
        eovf = 1;
      end else begin
        eres = int2bcd(ai + bi);
      end
    end else if (ai >= bi) begin
      eres = int2bcd(ai - bi);
    end else begin
`ifdef BCD_ALU_NEG_EN
      eres = int2bcd(bi - ai);
      eneg = 1;
      lat  = 2 * DIGITS + 1;
`else
      eovf = 1;
`endif
    end
  endtask

  task automatic model_reset();
    t0   = -100;
    lat  = 0;
    eres = '0;
    eovf = 0;
    eneg = 0;
    eerr = 0;
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    bit eb, ed, ev;
    eb = !eerr && cyc > t0 && cyc < t0 + lat;
    ed = (cyc == t0 + lat);
    ev = (cyc >= t0 + lat);
    chk("busy", busy, eb);
    chk("done", done, ed);
    if (ev) begin
      chk("result", result_bcd, eres);
      chk("ovf", ovf, eovf);
      chk("neg", neg, eneg);
      chk("err", err, eerr);
    end else begin
      chk("ovf_calc", ovf, 0);
      chk("neg_calc", neg, 0);
      chk("err_calc", err, 0);
    end
  end

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] opc, input bit now);
    if (!now) begin
      @(negedge clk);
      #1;
    end
    num1_bcd  = a;
    num2_bcd  = b;
    operation = opc;
    start     = 1'b1;
    model(a, b, opc);
  endtask

  task automatic wait_done(input logic [W-1:0] hres, input bit hovf,
                           input bit hneg, input int hlat,
                           input int skip);
    bit got;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = done;
      #1 start = 1'b0;
      if (got) begin
        chk("latency", i + 1 + skip, hlat);
        chk("res_hand", result_bcd, hres);
        chk("ovf_hand", ovf, hovf);
        chk("neg_hand", neg, hneg);
      end
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    launch(16'h1234, 16'h4321, 2'b00, 0);
    wait_done(16'h5555, 0, 0, 5, 0);

    launch(16'h9999, 16'h0001, 2'b01, 0);
    wait_done(16'h9999, 1, 0, 5, 0);

    launch(16'h0999, 16'h0001, 2'b00, 0);
    wait_done(16'h1000, 0, 0, 5, 0);

    launch(16'h0100, 16'h0001, 2'b10, 0);
    wait_done(16'h0099, 0, 0, 5, 0);

    launch(16'h0001, 16'h0100, 2'b10, 0);
`ifdef BCD_ALU_NEG_EN
    wait_done(16'h0099, 0, 1, 9, 0);
`else
    wait_done(16'h0000, 1, 0, 5, 0);
`endif

    launch(16'h1000, 16'h0001, 2'b10, 0);
    wait_done(16'h0999, 0, 0, 5, 0);

    launch(16'h4567, 16'h4567, 2'b10, 0);
    wait_done(16'h0000, 0, 0, 5, 0);

    launch(16'h12A4, 16'h0001, 2'b00, 0);
    wait_done(16'h0000, 0, 0, 1, 0);
    chk("err_hand", err, 1);

    launch(16'h0005, 16'h0004, 2'b11, 0);
    wait_done(16'h0009, 0, 0, 5, 0);
    chk("err_clear", err, 0);

    // start held while busy, operation flipped mid-flight
    launch(16'h1111, 16'h2222, 2'b00, 0);
    repeat (3) begin
      @(negedge clk);
      #1;
      start     = 1'b1;
      operation = 2'b10;
    end
    wait_done(16'h3333, 0, 0, 5, 3);

    // back-to-back: second start in the DONE cycle
    launch(16'h5000, 16'h5000, 2'b00, 0);
    wait_done(16'h9999, 1, 0, 5, 0);
    launch(16'h0002, 16'h0001, 2'b10, 1);
    wait_done(16'h0001, 0, 0, 5, 0);

    // reset while digit 2 is in flight
    launch(16'h1234, 16'h4321, 2'b00, 0);
    @(negedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", result_bcd, 0);
    chk("rst_flags", {ovf, neg, err}, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    launch(16'h0005, 16'h0005, 2'b00, 0);
    wait_done(16'h0010, 0, 0, 5, 0);

    repeat (3) @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
